// File: rtl/mips_pkg.sv
// Shared definitions for the multicycle MIPS core: opcodes, funct codes,
// ALU control codes, datapath mux selects and the controller state enum.
// Ports: none (package only).
package mips_pkg;

  localparam logic [5:0] OP_RTYPE = 6'h00;
  localparam logic [5:0] OP_LW    = 6'h23;
  localparam logic [5:0] OP_SW    = 6'h2B;
  localparam logic [5:0] OP_BEQ   = 6'h04;
  localparam logic [5:0] OP_ADDI  = 6'h08;
  localparam logic [5:0] OP_J     = 6'h02;

  localparam logic [5:0] FN_ADD = 6'h20;
  localparam logic [5:0] FN_SUB = 6'h22;
  localparam logic [5:0] FN_AND = 6'h24;
  localparam logic [5:0] FN_OR  = 6'h25;
  localparam logic [5:0] FN_SLT = 6'h2A;

  localparam logic [2:0] ALU_ADD = 3'b010;
  localparam logic [2:0] ALU_SUB = 3'b110;
  localparam logic [2:0] ALU_AND = 3'b000;
  localparam logic [2:0] ALU_OR  = 3'b001;
  localparam logic [2:0] ALU_SLT = 3'b111;

  // ALU operand B select
  localparam logic [1:0] SRCB_B      = 2'd0;
  localparam logic [1:0] SRCB_FOUR   = 2'd1;
  localparam logic [1:0] SRCB_IMM    = 2'd2;
  localparam logic [1:0] SRCB_IMM_SH = 2'd3;

  // Next-PC select
  localparam logic [1:0] PCSRC_ALU    = 2'd0;
  localparam logic [1:0] PCSRC_ALUOUT = 2'd1;
  localparam logic [1:0] PCSRC_JUMP   = 2'd2;

  typedef enum logic [3:0] {
    S_FETCH, S_DECODE, S_MEMADR, S_MEM_RD, S_WB_MEM, S_MEM_WR,
    S_EXEC_R, S_WB_R, S_EXEC_I, S_WB_I, S_BRANCH, S_JUMP, S_HALT
  } state_t;

  function automatic logic funct_ok(input logic [5:0] fn);
    return (fn == FN_ADD) || (fn == FN_SUB) || (fn == FN_AND) ||
           (fn == FN_OR)  || (fn == FN_SLT);
  endfunction

  function automatic logic [2:0] alu_ctrl_of(input logic [5:0] fn);
    case (fn)
      FN_SUB:  return ALU_SUB;
      FN_AND:  return ALU_AND;
      FN_OR:   return ALU_OR;
      FN_SLT:  return ALU_SLT;
      default: return ALU_ADD;
    endcase
  endfunction

endpackage

// File: rtl/ALU.sv
// Combinational ALU: add/sub/and/or/signed slt, wrapping arithmetic.
// Latency: combinational.
// Ports: i_ctrl (3-bit op), i_a, i_b -> o_y, o_zero (o_y == 0).
module ALU
  import mips_pkg::*;
#(
  parameter int DATA_WIDTH = 32
) (
  input  logic [2:0]            i_ctrl,
  input  logic [DATA_WIDTH-1:0] i_a,
  input  logic [DATA_WIDTH-1:0] i_b,
  output logic [DATA_WIDTH-1:0] o_y,
  output logic                  o_zero
);
  always_comb begin
    o_y = '0;
    case (i_ctrl)
      ALU_ADD: o_y = i_a + i_b;
      ALU_SUB: o_y = i_a - i_b;
      ALU_AND: o_y = i_a & i_b;
      ALU_OR:  o_y = i_a | i_b;
      ALU_SLT: o_y = DATA_WIDTH'($signed(i_a) < $signed(i_b));
      default: o_y = '0;
    endcase
  end

  assign o_zero = (o_y == '0);
endmodule

// File: rtl/MUX_2x1.sv
// Two-input multiplexer.
// Latency: combinational.
// Ports: i_sel (0 -> i_d0, 1 -> i_d1), o_y.
module MUX_2x1 #(
  parameter int WIDTH = 32
) (
  input  logic             i_sel,
  input  logic [WIDTH-1:0] i_d0,
  input  logic [WIDTH-1:0] i_d1,
  output logic [WIDTH-1:0] o_y
);
  assign o_y = i_sel ? i_d1 : i_d0;
endmodule

// File: rtl/RegisterFile.sv
// 32-entry register file, two async read ports, one sync write port; $0 reads 0.
// Latency: reads combinational, write lands on the rising edge.
// Ports: i_clk, i_rst (sync, high), i_we/i_wa/i_wd write, i_ra1/i_ra2 -> o_rd1/o_rd2.
module RegisterFile #(
  parameter int DATA_WIDTH = 32
) (
  input  logic                  i_clk,
  input  logic                  i_rst,
  input  logic                  i_we,
  input  logic [4:0]            i_ra1,
  input  logic [4:0]            i_ra2,
  input  logic [4:0]            i_wa,
  input  logic [DATA_WIDTH-1:0] i_wd,
  output logic [DATA_WIDTH-1:0] o_rd1,
  output logic [DATA_WIDTH-1:0] o_rd2
);
  logic [DATA_WIDTH-1:0] r_regs [32];

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      for (int i = 0; i < 32; i++) r_regs[i] <= '0;
    end else if (i_we && (i_wa != 5'd0)) begin
      r_regs[i_wa] <= i_wd;
    end
  end

  assign o_rd1 = (i_ra1 == 5'd0) ? '0 : r_regs[i_ra1];
  assign o_rd2 = (i_ra2 == 5'd0) ? '0 : r_regs[i_ra2];
endmodule

// File: rtl/SignExtend.sv
// Sign-extends a 16-bit immediate to DATA_WIDTH.
// Latency: combinational.
// Ports: i_imm -> o_y.
module SignExtend #(
  parameter int DATA_WIDTH = 32
) (
  input  logic [15:0]           i_imm,
  output logic [DATA_WIDTH-1:0] o_y
);
  assign o_y = {{(DATA_WIDTH-16){i_imm[15]}}, i_imm};
endmodule

// File: rtl/mips_mc_controller.sv
// Multicycle controller: state register plus decode into datapath enables.
// Latency: 3-5 states per instruction; request states stall while i_mem_ready is low.
// Ports: i_opcode/i_funct from IR, i_mem_ready, i_zero -> memory strobes, datapath enables, o_halt.
module mips_mc_controller
  import mips_pkg::*;
(
  input  logic       i_clk,
  input  logic       i_rst,
  input  logic [5:0] i_opcode,
  input  logic [5:0] i_funct,
  input  logic       i_mem_ready,
  input  logic       i_zero,
  output logic       o_mem_req,
  output logic       o_mem_we,
  output logic       o_iord,
  output logic       o_ir_write,
  output logic       o_pc_write,
  output logic [1:0] o_pc_src,
  output logic       o_reg_write,
  output logic       o_reg_dst,
  output logic       o_mem_to_reg,
  output logic       o_alu_src_a,
  output logic [1:0] o_alu_src_b,
  output logic [2:0] o_alu_ctrl,
  output logic       o_ab_write,
  output logic       o_aluout_write,
  output logic       o_mdr_write,
  output logic       o_halt
);
  state_t r_state;
  state_t w_next;

  always_ff @(posedge i_clk) begin
    if (i_rst) r_state <= S_FETCH;
    else       r_state <= w_next;
  end

  always_comb begin
    w_next         = r_state;
    o_mem_req      = 1'b0;
    o_mem_we       = 1'b0;
    o_iord         = 1'b0;
    o_ir_write     = 1'b0;
    o_pc_write     = 1'b0;
    o_pc_src       = PCSRC_ALU;
    o_reg_write    = 1'b0;
    o_reg_dst      = 1'b0;
    o_mem_to_reg   = 1'b0;
    o_alu_src_a    = 1'b0;
    o_alu_src_b    = SRCB_B;
    o_alu_ctrl     = ALU_ADD;
    o_ab_write     = 1'b0;
    o_aluout_write = 1'b0;
    o_mdr_write    = 1'b0;
    o_halt         = 1'b0;

    case (r_state)
      S_FETCH: begin
        // ALU computes PC+4 while the instruction is fetched
        o_mem_req   = 1'b1;
        o_alu_src_b = SRCB_FOUR;
        if (i_mem_ready) begin
          o_ir_write = 1'b1;
          o_pc_write = 1'b1;
          w_next     = S_DECODE;
        end
      end
      S_DECODE: begin
        // PC already holds PC+4, so this is the branch target
        o_ab_write     = 1'b1;
        o_alu_src_b    = SRCB_IMM_SH;
        o_aluout_write = 1'b1;
        case (i_opcode)
          OP_RTYPE:     w_next = funct_ok(i_funct) ? S_EXEC_R : S_HALT;
          OP_LW, OP_SW: w_next = S_MEMADR;
          OP_BEQ:       w_next = S_BRANCH;
          OP_ADDI:      w_next = S_EXEC_I;
          OP_J:         w_next = S_JUMP;
          default:      w_next = S_HALT;
        endcase
      end
      S_EXEC_R: begin
        o_alu_src_a    = 1'b1;
        o_alu_ctrl     = alu_ctrl_of(i_funct);
        o_aluout_write = 1'b1;
        w_next         = S_WB_R;
      end
      S_WB_R: begin
        o_reg_write = 1'b1;
        o_reg_dst   = 1'b1;
        w_next      = S_FETCH;
      end
      S_EXEC_I: begin
        o_alu_src_a    = 1'b1;
        o_alu_src_b    = SRCB_IMM;
        o_aluout_write = 1'b1;
        w_next         = S_WB_I;
      end
      S_WB_I: begin
        o_reg_write = 1'b1;
        w_next      = S_FETCH;
      end
      S_MEMADR: begin
        o_alu_src_a    = 1'b1;
        o_alu_src_b    = SRCB_IMM;
        o_aluout_write = 1'b1;
        w_next         = (i_opcode == OP_LW) ? S_MEM_RD : S_MEM_WR;
      end
      S_MEM_RD: begin
        o_mem_req = 1'b1;
        o_iord    = 1'b1;
        if (i_mem_ready) begin
          o_mdr_write = 1'b1;
          w_next      = S_WB_MEM;
        end
      end
      S_WB_MEM: begin
        o_reg_write  = 1'b1;
        o_mem_to_reg = 1'b1;
        w_next       = S_FETCH;
      end
      S_MEM_WR: begin
        o_mem_req = 1'b1;
        o_mem_we  = 1'b1;
        o_iord    = 1'b1;
        if (i_mem_ready) w_next = S_FETCH;
      end
      S_BRANCH: begin
        o_alu_src_a = 1'b1;
        o_alu_ctrl  = ALU_SUB;
        o_pc_src    = PCSRC_ALUOUT;
        o_pc_write  = i_zero;
        w_next      = S_FETCH;
      end
      S_JUMP: begin
        o_pc_src   = PCSRC_JUMP;
        o_pc_write = 1'b1;
        w_next     = S_FETCH;
      end
      S_HALT: begin
        o_halt = 1'b1;
      end
      default: w_next = S_FETCH;
    endcase

    // A reset cycle abandons any access in flight
    if (i_rst) begin
      o_mem_req = 1'b0;
      o_mem_we  = 1'b0;
    end
  end
endmodule

// File: rtl/mips_multicycle_core.sv
// Multicycle MIPS core with one shared instruction/data memory port.
// Latency: beq/j 3, R-type/addi/sw 4, lw 5 cycles plus one per low-MemReady request cycle.
// Ports: CLK, rst (sync, high); MemReq/MemWE/MemAddr/MemWData out, MemRData/MemReady in; PC, Halt debug.
module mips_multicycle_core
  import mips_pkg::*;
#(
  parameter int DATA_WIDTH    = 32,
  parameter int ADDRESS_WIDTH = 32,
  parameter logic [ADDRESS_WIDTH-1:0] RESET_PC = '0
) (
  input  logic                     CLK,
  input  logic                     rst,
  output logic                     MemReq,
  output logic                     MemWE,
  output logic [ADDRESS_WIDTH-1:0] MemAddr,
  output logic [DATA_WIDTH-1:0]    MemWData,
  input  logic [DATA_WIDTH-1:0]    MemRData,
  input  logic                     MemReady,
  output logic [ADDRESS_WIDTH-1:0] PC,
  output logic                     Halt
);
  logic [ADDRESS_WIDTH-1:0] r_pc;
  logic [31:0]              r_ir;
  logic [DATA_WIDTH-1:0]    r_a, r_b, r_aluout, r_mdr;

  logic                     w_iord, w_ir_write, w_pc_write, w_reg_write;
  logic                     w_reg_dst, w_mem_to_reg, w_alu_src_a;
  logic                     w_ab_write, w_aluout_write, w_mdr_write, w_zero;
  logic [1:0]               w_pc_src, w_alu_src_b;
  logic [2:0]               w_alu_ctrl;
  logic [4:0]               w_wa;
  logic [DATA_WIDTH-1:0]    w_rd1, w_rd2, w_wd, w_sign_imm;
  logic [DATA_WIDTH-1:0]    w_src_a, w_src_b, w_alu_y;
  logic [ADDRESS_WIDTH-1:0] w_pc_next, w_jump_target;

  mips_mc_controller u_ctrl (
    .i_clk         (CLK),
    .i_rst         (rst),
    .i_opcode      (r_ir[31:26]),
    .i_funct       (r_ir[5:0]),
    .i_mem_ready   (MemReady),
    .i_zero        (w_zero),
    .o_mem_req     (MemReq),
    .o_mem_we      (MemWE),
    .o_iord        (w_iord),
    .o_ir_write    (w_ir_write),
    .o_pc_write    (w_pc_write),
    .o_pc_src      (w_pc_src),
    .o_reg_write   (w_reg_write),
    .o_reg_dst     (w_reg_dst),
    .o_mem_to_reg  (w_mem_to_reg),
    .o_alu_src_a   (w_alu_src_a),
    .o_alu_src_b   (w_alu_src_b),
    .o_alu_ctrl    (w_alu_ctrl),
    .o_ab_write    (w_ab_write),
    .o_aluout_write(w_aluout_write),
    .o_mdr_write   (w_mdr_write),
    .o_halt        (Halt)
  );

  RegisterFile #(.DATA_WIDTH(DATA_WIDTH)) u_rf (
    .i_clk(CLK), .i_rst(rst), .i_we(w_reg_write),
    .i_ra1(r_ir[25:21]), .i_ra2(r_ir[20:16]), .i_wa(w_wa), .i_wd(w_wd),
    .o_rd1(w_rd1), .o_rd2(w_rd2)
  );

  SignExtend #(.DATA_WIDTH(DATA_WIDTH)) u_sext (.i_imm(r_ir[15:0]), .o_y(w_sign_imm));

  MUX_2x1 #(.WIDTH(5)) u_mux_dst (
    .i_sel(w_reg_dst), .i_d0(r_ir[20:16]), .i_d1(r_ir[15:11]), .o_y(w_wa)
  );
  MUX_2x1 #(.WIDTH(DATA_WIDTH)) u_mux_wd (
    .i_sel(w_mem_to_reg), .i_d0(r_aluout), .i_d1(r_mdr), .o_y(w_wd)
  );
  MUX_2x1 #(.WIDTH(DATA_WIDTH)) u_mux_a (
    .i_sel(w_alu_src_a), .i_d0(DATA_WIDTH'(r_pc)), .i_d1(r_a), .o_y(w_src_a)
  );
  MUX_2x1 #(.WIDTH(ADDRESS_WIDTH)) u_mux_addr (
    .i_sel(w_iord), .i_d0(r_pc), .i_d1(ADDRESS_WIDTH'(r_aluout)), .o_y(MemAddr)
  );

  always_comb begin
    w_src_b = r_b;
    case (w_alu_src_b)
      SRCB_FOUR:   w_src_b = DATA_WIDTH'(4);
      SRCB_IMM:    w_src_b = w_sign_imm;
      SRCB_IMM_SH: w_src_b = w_sign_imm << 2;
      default:     w_src_b = r_b;
    endcase
  end

  ALU #(.DATA_WIDTH(DATA_WIDTH)) u_alu (
    .i_ctrl(w_alu_ctrl), .i_a(w_src_a), .i_b(w_src_b), .o_y(w_alu_y), .o_zero(w_zero)
  );

  // Jump keeps the top nibble of the already-incremented PC
  assign w_jump_target = ADDRESS_WIDTH'({r_pc[31:28], r_ir[25:0], 2'b00});

  always_comb begin
    w_pc_next = ADDRESS_WIDTH'(w_alu_y);
    case (w_pc_src)
      PCSRC_ALUOUT: w_pc_next = ADDRESS_WIDTH'(r_aluout);
      PCSRC_JUMP:   w_pc_next = w_jump_target;
      default:      w_pc_next = ADDRESS_WIDTH'(w_alu_y);
    endcase
  end

  always_ff @(posedge CLK) begin
    if (rst) begin
      r_pc     <= RESET_PC;
      r_ir     <= '0;
      r_a      <= '0;
      r_b      <= '0;
      r_aluout <= '0;
      r_mdr    <= '0;
    end else begin
      if (w_pc_write)     r_pc     <= w_pc_next;
      if (w_ir_write)     r_ir     <= MemRData[31:0];
      if (w_ab_write) begin
        r_a <= w_rd1;
        r_b <= w_rd2;
      end
      if (w_aluout_write) r_aluout <= w_alu_y;
      if (w_mdr_write)    r_mdr    <= MemRData;
    end
  end

  assign MemWData = r_b;
  assign PC       = r_pc;
endmodule

// File: tb/tb_mips_multicycle_core.sv
// Directed bench for mips_multicycle_core with a behavioural unified memory.
// Latency: n/a (bench).
// Ports: none; drives CLK/rst and models the memory handshake.
module tb_mips_multicycle_core;
  logic        CLK = 1'b0;
  logic        rst = 1'b1;
  logic        MemReq, MemWE, Halt;
  logic [31:0] MemAddr, MemWData, PC;
  logic [31:0] MemRData = 32'h0;
  logic        MemReady = 1'b0;

  mips_multicycle_core #(.DATA_WIDTH(32), .ADDRESS_WIDTH(32), .RESET_PC(32'h0)) u_dut (
    .CLK(CLK), .rst(rst), .MemReq(MemReq), .MemWE(MemWE), .MemAddr(MemAddr),
    .MemWData(MemWData), .MemRData(MemRData), .MemReady(MemReady), .PC(PC), .Halt(Halt)
  );

  always #5 CLK = ~CLK;

  logic [31:0] mem [256];
  int          fs  [256];          // cycle at which the fetch of each word started
  int          cyc = 0, wait_cfg = 0, wait_cnt = 0, stall_viol = 0;
  int          wr8_cnt = 0, halt_req = 0;
  logic [31:0] wr8_data = 32'h0;
  bit          ready_noise = 1'b0, in_req = 1'b0;
  logic [31:0] hold_addr = 32'h0, hold_wd = 32'h0;
  logic        hold_we = 1'b0;
  int          n_chk = 0, n_pass = 0;

  // Memory response, computed away from the active edge
  always @(negedge CLK) begin
    if (MemReq) begin
      MemRData = mem[MemAddr[9:2]];
      if (wait_cnt < wait_cfg) begin
        MemReady = 1'b0;
        wait_cnt++;
      end else begin
        MemReady = 1'b1;
      end
    end else begin
      MemReady = ready_noise;
      wait_cnt = 0;
    end
  end

  // Transaction monitor: sees pre-edge values at the active edge
  always @(posedge CLK) begin
    cyc++;
    if (Halt && MemReq) halt_req++;
    if (MemReq) begin
      if (!in_req) begin
        in_req    = 1'b1;
        hold_addr = MemAddr;
        hold_we   = MemWE;
        hold_wd   = MemWData;
        if (!MemWE && MemAddr == PC) fs[MemAddr[9:2]] = cyc;
      end else if (MemAddr !== hold_addr || MemWE !== hold_we ||
                   (MemWE && MemWData !== hold_wd)) begin
        stall_viol++;
      end
      if (MemReady) begin
        in_req   = 1'b0;
        wait_cnt = 0;
        if (MemWE) begin
          mem[MemAddr[9:2]] = MemWData;
          if (MemAddr == 32'h8) begin
            wr8_cnt++;
            wr8_data = MemWData;
          end
        end
      end
    end else begin
      in_req = 1'b0;
    end
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s: observed 0x%08h expected 0x%08h", tag, obs, exp);
  endtask

  task automatic cycles(input int n);
    repeat (n) @(posedge CLK);
    #1;
  endtask

  task automatic run_until_halt(input int max_cyc);
    int n;
    n = 0;
    while (!Halt && n < max_cyc) begin
      @(posedge CLK);
      #1;
      n++;
    end
  endtask

  function automatic logic [31:0] ei(input logic [5:0] op, input logic [4:0] rs,
                                     input logic [4:0] rt, input logic [15:0] imm);
    return {op, rs, rt, imm};
  endfunction

  function automatic logic [31:0] er(input logic [4:0] rs, input logic [4:0] rt,
                                     input logic [4:0] rd, input logic [5:0] fn);
    return {6'h00, rs, rt, rd, 5'd0, fn};
  endfunction

  task automatic load_prog();
    for (int i = 0; i < 256; i++) begin
      mem[i] = 32'hDEAD_BEEF;
      fs[i]  = -1;
    end
    mem[0]  = ei(6'h08, 5'd0, 5'd1, 16'd5);       // addi $1,$0,5
    mem[1]  = ei(6'h08, 5'd0, 5'd2, 16'hFFFD);    // addi $2,$0,-3
    mem[2]  = er(5'd1, 5'd2, 5'd3, 6'h20);        // add  $3,$1,$2
    mem[3]  = er(5'd2, 5'd1, 5'd4, 6'h2A);        // slt  $4,$2,$1
    mem[4]  = ei(6'h2B, 5'd0, 5'd3, 16'h0080);    // sw   $3,0x80($0)
    mem[5]  = ei(6'h2B, 5'd0, 5'd4, 16'h0084);    // sw   $4,0x84($0)
    mem[6]  = ei(6'h2B, 5'd0, 5'd1, 16'h0008);    // sw   $1,8($0)
    mem[7]  = ei(6'h23, 5'd0, 5'd5, 16'h0008);    // lw   $5,8($0)
    mem[8]  = ei(6'h04, 5'd1, 5'd1, 16'd2);       // 0x20 beq $1,$1,+2
    mem[9]  = ei(6'h08, 5'd0, 5'd6, 16'd1);       // skipped
    mem[10] = ei(6'h08, 5'd0, 5'd6, 16'd2);       // skipped
    mem[11] = {6'h02, 26'h40};                    // 0x2C j 0x40
    mem[64] = ei(6'h2B, 5'd0, 5'd5, 16'h0088);    // 0x100 sw $5,0x88($0)
    mem[65] = ei(6'h04, 5'd1, 5'd2, 16'd5);       // beq $1,$2 (not taken)
    mem[66] = ei(6'h2B, 5'd0, 5'd6, 16'h008C);    // sw $6,0x8C($0)
    mem[67] = ei(6'h08, 5'd0, 5'd0, 16'd7);       // addi $0,$0,7
    mem[68] = ei(6'h2B, 5'd0, 5'd0, 16'h0090);    // sw $0,0x90($0)
    mem[69] = er(5'd2, 5'd1, 5'd7, 6'h22);        // sub $7,$2,$1
    mem[70] = er(5'd1, 5'd2, 5'd8, 6'h24);        // and $8,$1,$2
    mem[71] = er(5'd1, 5'd2, 5'd9, 6'h25);        // or  $9,$1,$2
    mem[72] = ei(6'h2B, 5'd0, 5'd7, 16'h0094);
    mem[73] = ei(6'h2B, 5'd0, 5'd8, 16'h0098);
    mem[74] = ei(6'h2B, 5'd0, 5'd9, 16'h009C);
    mem[75] = 32'hFC00_0000;                      // 0x12C opcode 0x3F
    wr8_cnt    = 0;
    stall_viol = 0;
  endtask

  task automatic check_results(input string p);
    check({p, "_halt"},      32'(Halt), 32'd1);
    check({p, "_halt_pc"},   PC, 32'h130);
    check({p, "_add"},       mem[32], 32'd2);
    check({p, "_slt"},       mem[33], 32'd1);
    check({p, "_sw8_cnt"},   wr8_cnt, 32'd1);
    check({p, "_sw8_data"},  wr8_data, 32'd5);
    check({p, "_lw"},        mem[34], 32'd5);
    check({p, "_skip_reg"},  mem[35], 32'd0);
    check({p, "_skip_fetch"}, fs[9], 32'hFFFF_FFFF);
    check({p, "_r0"},        mem[36], 32'd0);
    check({p, "_sub"},       mem[37], 32'hFFFF_FFF8);
    check({p, "_and"},       mem[38], 32'd5);
    check({p, "_or"},        mem[39], 32'hFFFF_FFFD);
    check({p, "_stall_stable"}, stall_viol, 32'd0);
  endtask

  // w = extra cycles per memory access
  task automatic check_lat(input string p, input int w);
    check({p, "_lat_addi"},   fs[1]  - fs[0],  4 + w);
    check({p, "_lat_add"},    fs[3]  - fs[2],  4 + w);
    check({p, "_lat_sw"},     fs[7]  - fs[6],  4 + 2*w);
    check({p, "_lat_lw"},     fs[8]  - fs[7],  5 + 2*w);
    check({p, "_lat_beq_t"},  fs[11] - fs[8],  3 + w);
    check({p, "_lat_j"},      fs[64] - fs[11], 3 + w);
    check({p, "_lat_beq_nt"}, fs[66] - fs[65], 3 + w);
  endtask

  initial begin
    // Run 1: zero-wait memory
    load_prog();
    @(posedge CLK); #1;
    check("rst_memreq", 32'(MemReq), 32'd0);
    check("rst_memwe",  32'(MemWE), 32'd0);
    check("rst_pc",     PC, 32'h0);
    check("rst_halt",   32'(Halt), 32'd0);
    @(posedge CLK); #1;
    rst = 1'b0;
    #1;
    check("first_req",  32'(MemReq), 32'd1);
    check("first_addr", MemAddr, 32'h0);
    cycles(16);
    check("pc_after_16", PC, 32'h10);
    run_until_halt(2000);
    check_results("z");
    check_lat("z", 0);
    halt_req = 0;
    cycles(20);
    check("halt_no_req", halt_req, 32'd0);
    check("halt_sticky", 32'(Halt), 32'd1);

    // Run 2: three wait cycles per access, ready toggled high when idle
    rst = 1'b1;
    load_prog();
    wait_cfg    = 3;
    ready_noise = 1'b1;
    @(posedge CLK); #1;
    check("rst2_pc",     PC, 32'h0);
    check("rst2_halt",   32'(Halt), 32'd0);
    check("rst2_memreq", 32'(MemReq), 32'd0);
    rst = 1'b0;
    run_until_halt(4000);
    check_results("w");
    check_lat("w", 3);

    // Run 3: reset during a stalled fetch
    rst = 1'b1;
    load_prog();
    wait_cfg    = 0;
    ready_noise = 1'b0;
    cycles(2);
    rst = 1'b0;
    cycles(8);
    wait_cfg = 50;
    cycles(3);
    check("stall_pc",   PC, 32'h8);
    check("stall_req",  32'(MemReq), 32'd1);
    check("stall_addr", MemAddr, 32'h8);
    rst = 1'b1;
    #1;
    check("midrst_req", 32'(MemReq), 32'd0);
    @(posedge CLK); #1;
    check("midrst_pc",  PC, 32'h0);
    check("midrst_req_hold", 32'(MemReq), 32'd0);
    rst = 1'b0;
    wait_cfg = 0;
    #1;
    check("restart_req",  32'(MemReq), 32'd1);
    check("restart_addr", MemAddr, 32'h0);
    cycles(16);
    check("restart_pc_16", PC, 32'h10);
    run_until_halt(2000);
    check_results("r");

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule

// File: doc/mips_multicycle_core.md
# mips_multicycle_core

Multicycle MIPS core: one shared memory port with a request/ready handshake, an internal controller FSM, and a datapath whose registers hold values between steps. It follows the single-cycle datapath and runs the same instruction subset. Instruction fetch and data access share one memory, so each instruction takes 3–5 cycles plus memory wait cycles. The core sits between the top-level testbench/SoC and a unified instruction/data memory.

## Interface
- DATA_WIDTH, 32: register, ALU and memory data width (≥32; instruction fields are fixed MIPS-32 positions in the low 32 bits).
- ADDRESS_WIDTH, 32: PC and memory address width.
- RESET_PC, 0: PC value loaded on reset.
- CLK  in  1  single clock; all state updates on rising edge.
- rst  in  1  reset: synchronous, active-high.
- MemReq  out  1  memory access request; held high until MemReady is sampled high.
- MemWE  out  1  write strobe; valid only while MemReq is high.
- MemAddr  out  ADDRESS_WIDTH  byte address; stable while MemReq is high.
- MemWData  out  DATA_WIDTH  store data; stable while MemReq and MemWE are high.
- MemRData  in  DATA_WIDTH  read data; valid in the cycle MemReady is high.
- MemReady  in  1  access completes on the edge where MemReq and MemReady are both high.
- PC  out  ADDRESS_WIDTH  current program counter (debug).
- Halt  out  1  sticky; set on an illegal opcode or funct.

## Operation
- Supported instructions:
  - R-type add/sub/and/or/slt (funct 0x20/0x22/0x24/0x25/0x2A).
  - lw 0x23, sw 0x2B, beq 0x04, addi 0x08, j 0x02.
- FSM states and transitions:
  - FETCH: MemReq=1, MemWE=0, MemAddr=PC. On ready: IR←MemRData, PC←PC+4, go to DECODE.
  - DECODE: A←RF[rs], B←RF[rt], ALUOut←PC+(SignImm<<2), which is the branch target. Then:
    - R-type → EXEC_R
    - lw/sw → MEMADR
    - beq → BRANCH
    - addi → EXEC_I
    - j → JUMP
    - anything else → HALT
  - EXEC_R: ALUOut←A op B → WB_R. WB_R: RF[rd]←ALUOut → FETCH.
  - EXEC_I: ALUOut←A+SignImm → WB_I. WB_I: RF[rt]←ALUOut → FETCH.
  - MEMADR: ALUOut←A+SignImm.
    - lw → MEM_RD
    - sw → MEM_WR
  - MEM_RD: request at ALUOut; on ready MDR←MemRData → WB_MEM. WB_MEM: RF[rt]←MDR → FETCH.
  - MEM_WR: MemWE=1, MemWData=B, request at ALUOut; on ready → FETCH.
  - BRANCH: if A==B then PC←ALUOut; → FETCH.
  - JUMP: PC←{PC[top 4 bits], IR[25:0], 2'b00}, zero-extended to ADDRESS_WIDTH if wider than 32; → FETCH.
  - HALT: terminal; no further requests; Halt=1 until rst.
- Register $0 always reads 0; writes to it are discarded.
- Arithmetic wraps modulo 2^DATA_WIDTH; no overflow trap. slt is a signed compare producing 0 or 1.
- SignImm is IR[15:0] sign-extended to DATA_WIDTH.
- Address misalignment is not checked; MemAddr carries ALUOut unchanged.

## Timing
- Reset values:
  - PC=RESET_PC; all registers, IR, A, B, ALUOut, MDR = 0.
  - State=FETCH; Halt=0.
  - MemReq=0 and MemWE=0 during every cycle rst is high.
  - The first request is issued in the first cycle after rst deasserts.
- Memory outputs are registered/Moore: they depend on state only, never combinationally on MemReady.
- Zero-wait latency per instruction (MemReady high in the first request cycle):
  - beq, j: 3 cycles
  - R-type, addi, sw: 4 cycles
  - lw: 5 cycles
- Each low MemReady cycle in FETCH/MEM_RD/MEM_WR adds exactly one cycle. Address, data and WE are held constant throughout.
- MemReady while MemReq=0 is ignored.
- rst mid-access abandons the transaction: MemReq=0 from the reset cycle onward, and no partial register or PC update occurs.
- PC output updates on the edge that completes FETCH, BRANCH-taken or JUMP.

## Structure
- Package mips_pkg holds:
  - opcode and funct localparams;
  - 3-bit ALU control codes (010 add, 110 sub, 000 and, 001 or, 111 slt);
  - the FSM state enum.
- Sub-module mips_mc_controller: FSM plus decode, producing the datapath enables (IRWrite, PCWrite, RegWrite, ALUSrcA/B, IorD, MemtoReg, RegDst, Halt).
- The datapath instantiates the existing RegisterFile, ALU, SignExtend and MUX_2x1 blocks, parametrised by DATA_WIDTH.

## Test plan
- Reset then R-type program:
  - Stimulus: rst held 2 cycles; memory holds addi $1,$0,5; addi $2,$0,-3; add $3,$1,$2; slt $4,$2,$1.
  - Required: $3=2, $4=1; PC=0x10 after 16 cycles with zero-wait memory.
- Load/store round-trip:
  - Stimulus: sw $1,8($0), then lw $5,8($0).
  - Required: one MemWE=1 request at address 8 with data 5; $5=5; lw completes in exactly 5 cycles.
- Wait states:
  - Stimulus: MemReady held low 3 cycles on every access.
  - Required: identical register results; each access +3 cycles; MemAddr, MemWData and MemWE constant across the stall.
- Branch and jump:
  - Stimulus: beq $1,$1,+2 at 0x20.
  - Required: PC=0x2C. With unequal operands, PC=0x24.
  - Stimulus: j 0x40 at 0x2C.
  - Required: PC=0x100.
- Illegal opcode and $0:
  - Stimulus: addi $0,$0,7, then opcode 0x3F.
  - Required: $0 still reads 0; Halt=1 and MemReq stays 0 permanently; rst restores PC=RESET_PC and Halt=0.
- Reset mid-fetch:
  - Stimulus: rst asserted during a stalled FETCH.
  - Required: MemReq=0 in the rst cycle; no IR or PC change; fetch restarts at RESET_PC.
